// File: rtl/serial_operand_tx.sv
// Serialises two W-bit operands as a stream of bit pairs, MSB or LSB first,
// under a valid/ready handshake with a one-cycle done pulse per frame.
module serial_operand_tx #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ready,
    output logic         a_bit,
    output logic         b_bit,
    output logic         bit_valid,
    output logic         first_bit,
    output logic         last_bit,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic          mode_q;
    logic [CW-1:0] cnt;
    logic          xfer;
    logic          load;

    // Handshake: a pair moves when bit_valid and ready are both high at a
    // rising edge; otherwise the current pair is held unchanged indefinitely.
    assign xfer = (state == SHIFT) && ready;
    assign load = (state == IDLE) && start;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (xfer && (cnt == LAST_IDX)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            mode_q <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                a_sr   <= a;
                b_sr   <= b;
                mode_q <= mode;
                cnt    <= '0;
            end else if (xfer) begin
                // Shift toward the output end so the next bit lands at the tap.
                if (mode_q) begin
                    a_sr <= {1'b0, a_sr[W-1:1]};
                    b_sr <= {1'b0, b_sr[W-1:1]};
                end else begin
                    a_sr <= {a_sr[W-2:0], 1'b0};
                    b_sr <= {b_sr[W-2:0], 1'b0};
                end
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign bit_valid = (state == SHIFT);
    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign a_bit     = bit_valid & (mode_q ? a_sr[0] : a_sr[W-1]);
    assign b_bit     = bit_valid & (mode_q ? b_sr[0] : b_sr[W-1]);
    assign first_bit = bit_valid && (cnt == '0);
    assign last_bit  = bit_valid && (cnt == LAST_IDX);

endmodule

// File: tb/tb_serial_operand_tx.sv
// Directed bench for serial_operand_tx: frames in both bit orders, stalls,
// ignored starts, mid-frame reset and back-to-back frames.
module tb_serial_operand_tx;

    localparam int W = 32;
    localparam logic [W-1:0] A1 = 32'h9292_B292;
    localparam logic [W-1:0] B1 = 32'h9292_9292;

    logic         clk;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         a_bit;
    logic         b_bit;
    logic         bit_valid;
    logic         first_bit;
    logic         last_bit;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;
    bit hold_start = 1'b0;

    serial_operand_tx #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .bit_valid (bit_valid),
        .first_bit (first_bit),
        .last_bit  (last_bit),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, bit_valid, 0);
        chk({tag, "_busy"},  busy,      0);
        chk({tag, "_done"},  done,      0);
        chk({tag, "_abit"},  a_bit,     0);
        chk({tag, "_bbit"},  b_bit,     0);
        chk({tag, "_first"}, first_bit, 0);
        chk({tag, "_last"},  last_bit,  0);
    endtask

    // Leaves the bench at the falling edge where pair 0 is visible.
    task automatic start_frame(input logic [W-1:0] av, input logic [W-1:0] bv, input logic m);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        mode  = m;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
    endtask

    // Checks every pair of one frame against the expected operands, then the
    // done cycle. Edge count runs from the start edge to the edge that samples done.
    task automatic recv(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                        input logic m, input int s0, input int s1, input int s2,
                        input int start_at, input int rst_at, input bit scramble,
                        input int exp_edges, output int mcnt, output int midx);
        int   n;
        logic xa;
        logic xb;
        n    = 0;
        mcnt = 0;
        midx = -1;
        for (int i = 0; i < W; i++) begin
            if (i > 0) begin
                @(negedge clk);
                n++;
                if (!hold_start) start = 1'b0;
            end
            xa = m ? ea[i] : ea[W-1-i];
            xb = m ? eb[i] : eb[W-1-i];
            chk($sformatf("%s_valid%0d", tag, i), bit_valid, 1);
            chk($sformatf("%s_busy%0d", tag, i),  busy,      1);
            chk($sformatf("%s_a%0d", tag, i),     a_bit,     xa);
            chk($sformatf("%s_b%0d", tag, i),     b_bit,     xb);
            chk($sformatf("%s_first%0d", tag, i), first_bit, (i == 0));
            chk($sformatf("%s_last%0d", tag, i),  last_bit,  (i == W - 1));
            if (a_bit !== b_bit) begin
                mcnt++;
                if (midx < 0) midx = i;
            end
            if (scramble) begin
                a    = $urandom;
                b    = $urandom;
                mode = 1'($urandom_range(0, 1));
            end
            if (i == start_at) begin
                start = 1'b1;
                a     = '1;
            end
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk_idle($sformatf("%s_rst", tag));
                return;
            end
            if (i == s0 || i == s1 || i == s2) begin
                ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    n++;
                    chk($sformatf("%s_stv%0d", tag, i), bit_valid, 1);
                    chk($sformatf("%s_sta%0d", tag, i), a_bit,     xa);
                    chk($sformatf("%s_stb%0d", tag, i), b_bit,     xb);
                    chk($sformatf("%s_stf%0d", tag, i), first_bit, (i == 0));
                    chk($sformatf("%s_stl%0d", tag, i), last_bit,  (i == W - 1));
                end
                ready = 1'b1;
            end
        end
        @(negedge clk);
        n++;
        if (!hold_start) start = 1'b0;
        chk({tag, "_done"},      done,      1);
        chk({tag, "_done_vld"},  bit_valid, 0);
        chk({tag, "_done_busy"}, busy,      0);
        chk({tag, "_done_last"}, last_bit,  0);
        if (exp_edges > 0) chk({tag, "_edges"}, n + 1, exp_edges);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mc;
        int mi;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a     = '0;
        b     = '0;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        // Start together with reset must be lost.
        start = 1'b1;
        a     = A1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        chk_idle("rst_start");
        @(negedge clk);
        chk_idle("rst_start2");

        // 1: MSB first, continuous ready.
        start_frame(A1, B1, 1'b0);
        recv("s1", A1, B1, 1'b0, -1, -1, -1, -1, -1, 1'b0, 33, mc, mi);
        chk("s1_mism_cnt", mc, 1);
        chk("s1_mism_idx", mi, 18);
        @(negedge clk);
        chk_idle("s1_after");

        // 2: LSB first.
        start_frame(A1, B1, 1'b1);
        recv("s2", A1, B1, 1'b1, -1, -1, -1, -1, -1, 1'b0, 33, mc, mi);
        chk("s2_mism_cnt", mc, 1);
        chk("s2_mism_idx", mi, 13);
        @(negedge clk);
        chk_idle("s2_after");

        // 3: three-cycle stalls on pairs 0, 5 and 31.
        start_frame(A1, B1, 1'b0);
        recv("s3", A1, B1, 1'b0, 0, 5, 31, -1, -1, 1'b0, 42, mc, mi);
        @(negedge clk);
        chk_idle("s3_after");

        // 4: start pulse mid-frame and operands churning after the start edge.
        start_frame(A1, B1, 1'b0);
        recv("s4", A1, B1, 1'b0, -1, -1, -1, 10, -1, 1'b1, 33, mc, mi);
        @(negedge clk);
        chk_idle("s4_after");

        // 5: reset at pair 20, then a fresh full frame.
        start_frame(A1, B1, 1'b0);
        recv("s5", A1, B1, 1'b0, -1, -1, -1, -1, 20, 1'b0, 33, mc, mi);
        repeat (3) begin
            @(negedge clk);
            chk_idle("s5_quiet");
        end
        start_frame(32'h0123_4567, 32'hFEDC_BA98, 1'b1);
        recv("s5b", 32'h0123_4567, 32'hFEDC_BA98, 1'b1, -1, -1, -1, -1, -1, 1'b0, 33, mc, mi);
        @(negedge clk);
        chk_idle("s5b_after");

        // 6: start held high across frames.
        hold_start = 1'b1;
        start_frame(32'hA5A5_0F0F, 32'h3C3C_F00F, 1'b0);
        recv("s6a", 32'hA5A5_0F0F, 32'h3C3C_F00F, 1'b0, -1, -1, -1, -1, -1, 1'b0, 33, mc, mi);
        @(negedge clk);
        chk("s6_idle_vld",  bit_valid, 0);
        chk("s6_idle_done", done,      0);
        @(negedge clk);
        chk("s6_shift_vld",   bit_valid, 1);
        chk("s6_shift_first", first_bit, 1);
        recv("s6b", 32'hA5A5_0F0F, 32'h3C3C_F00F, 1'b0, -1, -1, -1, -1, -1, 1'b0, -1, mc, mi);
        hold_start = 1'b0;
        start      = 1'b0;
        @(negedge clk);
        chk_idle("s6_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_operand_tx.md
SERIAL_OPERAND_TX -- requirements
Module: serial_operand_tx

Interface
REQ-001 Parameter: W, 32, operand width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: start  input  1  load request; honoured only in IDLE.
REQ-005 Port: mode  input  1  bit order, sampled with start; 0 = MSB first, 1 = LSB first.
REQ-006 Port: a  input  W  first operand, sampled with start.
REQ-007 Port: b  input  W  second operand, sampled with start.
REQ-008 Port: ready  input  1  downstream receiver accepts the current bit pair.
REQ-009 Port: a_bit  output  1  current serial bit of a.
REQ-010 Port: b_bit  output  1  current serial bit of b.
REQ-011 Port: bit_valid  output  1  a_bit/b_bit hold a valid pair.
REQ-012 Port: first_bit  output  1  current pair is bit 0 of the frame.
REQ-013 Port: last_bit  output  1  current pair is bit W-1 of the frame.
REQ-014 Port: busy  output  1  a frame is loaded and not yet fully sent.
REQ-015 Port: done  output  1  one-cycle pulse after the last pair is accepted.

Function
REQ-016 FSM states SHALL be IDLE, SHIFT and DONE, with the following transitions:
- IDLE -> SHIFT on start.
- SHIFT -> DONE when a transfer occurs with last_bit = 1.
- DONE -> IDLE unconditionally after one cycle.
REQ-017 On start in IDLE: latch a, b and mode into shadow shift registers; clear the bit counter (ceil(log2 W)+1 bits wide); enter SHIFT on the next edge.
REQ-018 Latency: start sampled at edge k -> bit_valid=1 with the first pair from edge k onward (visible in cycle k+1).
REQ-019 Transfer = bit_valid && ready at a rising edge; exactly one pair is consumed per transfer.
REQ-020 On transfer: shift both registers by one (left if mode=0, right if mode=1); counter +1.
REQ-021 Without ready, a_bit, b_bit, first_bit and last_bit SHALL hold stable (stall, no data loss, unlimited duration).
REQ-022 a_bit/b_bit = register MSB when mode=0, register LSB when mode=1.
REQ-023 first_bit = bit_valid && counter==0.
REQ-024 last_bit = bit_valid && counter==W-1.
REQ-025 bit_valid and busy = 1 exactly in SHIFT.
REQ-026 done = 1 exactly in DONE; bit_valid = 0 in DONE.
REQ-027 A frame is exactly W transfers; with continuous ready it spans W cycles, start to done = W+1 edges.
REQ-028 start while in SHIFT or DONE SHALL be ignored; the operands, mode and frame in progress are unaffected.
REQ-029 Changes on a, b or mode after the start edge SHALL NOT affect the frame in progress.
REQ-030 start asserted in the same cycle as done SHALL be ignored; a new frame starts no earlier than the cycle after done.

Reset
REQ-031 rst SHALL take priority over every other input.
REQ-032 On rst: state IDLE; counter and shift registers 0; a_bit, b_bit, bit_valid, first_bit, last_bit, busy and done all 0.
REQ-033 rst mid-frame SHALL abort the frame: no done pulse, remaining bits discarded, IDLE on the next cycle.
REQ-034 rst and start asserted together SHALL leave the block in IDLE; start is lost.

Verification
REQ-035 Scenario 1, basic MSB-first frame.
- Stimulus: W=32, mode=0, a=0x9292B292, b=0x92929292, ready tied 1.
- Required response: pairs 0..31 equal a[31-i], b[31-i]; the only mismatch is at i=18 (bit 13, a=1, b=0); first_bit at i=0, last_bit at i=31; done exactly 33 edges after start.
REQ-036 Scenario 2, LSB-first frame.
- Stimulus: same operands as scenario 1, mode=1.
- Required response: pair i equals a[i], b[i]; the mismatch appears at i=13.
REQ-037 Scenario 3, stalls.
- Stimulus: ready=0 on pairs 0, 5 and 31, three cycles each.
- Required response: outputs frozen during each stall; the full sequence matches scenario 1; done 9 cycles later than in scenario 1.
REQ-038 Scenario 4, ignored start and late operand changes.
- Stimulus: start pulsed at pair 10 with a=0xFFFFFFFF; a changed during the frame.
- Required response: the transmitted frame is unchanged; busy stays 1 throughout.
REQ-039 Scenario 5, reset mid-frame.
- Stimulus: rst pulsed at pair 20.
- Required response: next cycle all outputs 0; no done pulse; a fresh start afterwards sends a complete 32-pair frame.
REQ-040 Scenario 6, back-to-back frames.
- Stimulus: start held high continuously.
- Required response: start is ignored in DONE; the second frame begins its SHIFT state two cycles after done.
